// File: rtl/hub_bcm_driver.sv
// HUB-style LED panel driver: binary-coded modulation over CHANNELS parallel data lines,
// with the next plane shifting in while the current plane is displayed.
module hub_bcm_driver #(
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int BITS           = 8,
  parameter int ROW_ADDR_WIDTH = 3,
  parameter int ROW_PIXELS     = 416,
  parameter int FB_ADDR_WIDTH  = 12,
  parameter int BASE_ON        = 32
) (
  input  logic                           clk_48mhz,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [7:0]                     brightness,
  output logic [FB_ADDR_WIDTH-1:0]       fb_addr,
  output logic [CHANNELS-1:0]            panel_data,
  output logic                           panel_clk,
  output logic                           panel_latch,
  output logic                           panel_oe_n,
  output logic [ROW_ADDR_WIDTH-1:0]      panel_addr,
  output logic                           frame_done,
  output logic [3:0]                     dbg_state
);

  localparam int X_W     = $clog2(ROW_PIXELS + 1);
  localparam int MAX_WIN = BASE_ON << (BITS - 1);
  localparam int CNT_W   = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
  localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int PROD_W  = CNT_W + 9;

  // Handshake: fb_addr is held for the cycle it is presented; data_in is taken as valid
  // exactly one cycle later. The panel samples panel_data on the rising edge of panel_clk,
  // and panel_data is stable across the SETUP/RISE pair of each pixel.
  typedef enum logic [2:0] {
    SH_FETCH,
    SH_SETUP,
    SH_RISE,
    SH_WAIT,
    SH_LATCH
  } sh_state_t;

  sh_state_t                 sh_state;
  logic [X_W-1:0]            x;
  logic [ROW_ADDR_WIDTH-1:0] row;
  logic [PLANE_W-1:0]        plane;

  logic                      disp_on;
  logic [PLANE_W-1:0]        disp_plane;
  logic [CNT_W-1:0]          on_cnt;
  logic [CNT_W-1:0]          thresh;

  logic [CNT_W:0]            disp_win;
  logic                      disp_last;
  logic                      latch_ready;
  logic [PROD_W-1:0]         prod;
  logic [CNT_W-1:0]          new_thresh;

  function automatic logic [CNT_W:0] win_of(input logic [PLANE_W-1:0] p);
    return (CNT_W + 1)'(BASE_ON) << p;
  endfunction

  function automatic logic [FB_ADDR_WIDTH-1:0] addr_of(input logic [ROW_ADDR_WIDTH-1:0] r,
                                                       input logic [X_W-1:0] px);
    return FB_ADDR_WIDTH'(32'(r) * 32'(ROW_PIXELS) + 32'(px));
  endfunction

  assign dbg_state = {disp_on, sh_state};

  always_comb begin
    disp_win    = win_of(disp_plane);
    disp_last   = disp_on && ({1'b0, on_cnt} == disp_win - 1'b1);
    latch_ready = !disp_on || disp_last;
    // Full-width product so the >>8 keeps every significant bit of window*brightness.
    prod        = PROD_W'(win_of(plane)) * PROD_W'(brightness);
    new_thresh  = prod[8 +: CNT_W];
  end

  always_comb begin
    panel_data = '0;
    if (sh_state == SH_SETUP || sh_state == SH_RISE) begin
      for (int c = 0; c < CHANNELS; c++) begin
        panel_data[c] = data_in[c*DATA_WIDTH + (DATA_WIDTH - BITS) + int'(plane)];
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sh_state    <= SH_FETCH;
      x           <= '0;
      row         <= '0;
      plane       <= '0;
      fb_addr     <= '0;
      panel_clk   <= 1'b0;
      panel_latch <= 1'b0;
      panel_addr  <= '0;
      frame_done  <= 1'b0;
      disp_on     <= 1'b0;
      disp_plane  <= '0;
      on_cnt      <= '0;
      thresh      <= '0;
      panel_oe_n  <= 1'b1;
    end else begin
      frame_done <= 1'b0;

      if (disp_on) begin
        if (disp_last) begin
          disp_on    <= 1'b0;
          panel_oe_n <= 1'b1;
        end else begin
          on_cnt     <= on_cnt + 1'b1;
          panel_oe_n <= !((on_cnt + 1'b1) < thresh);
        end
      end

      case (sh_state)
        SH_FETCH: sh_state <= SH_SETUP;
        SH_SETUP: begin
          sh_state  <= SH_RISE;
          panel_clk <= 1'b1;
          x         <= x + 1'b1;
          fb_addr   <= addr_of(row, x + 1'b1);
        end
        SH_RISE: begin
          panel_clk <= 1'b0;
          sh_state  <= (x == X_W'(ROW_PIXELS)) ? SH_WAIT : SH_SETUP;
        end
        // The cycle that leaves WAIT is the single blanking cycle before the latch strobe.
        SH_WAIT: begin
          if (latch_ready) begin
            sh_state    <= SH_LATCH;
            panel_latch <= 1'b1;
            panel_addr  <= row;
          end
        end
        SH_LATCH: begin
          panel_latch <= 1'b0;
          sh_state    <= SH_FETCH;
          x           <= '0;
          disp_on     <= 1'b1;
          on_cnt      <= '0;
          disp_plane  <= plane;
          thresh      <= new_thresh;
          panel_oe_n  <= (new_thresh == '0);
          frame_done  <= (plane == PLANE_W'(BITS - 1)) && (&row);
          if (plane == PLANE_W'(BITS - 1)) begin
            plane   <= '0;
            row     <= row + 1'b1;
            fb_addr <= addr_of(row + 1'b1, '0);
          end else begin
            plane   <= plane + 1'b1;
            fb_addr <= addr_of(row, '0);
          end
        end
        default: sh_state <= SH_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hub_bcm_driver.sv
// Bench for hub_bcm_driver: a short-row instance checked event-by-event against a timing
// model, plus a long-row instance checked for latch period and lit time.
module tb_hub_bcm_driver;

  localparam int CH   = 2;
  localparam int DW   = 8;
  localparam int BITS = 2;
  localparam int RAW  = 1;
  localparam int RP   = 4;
  localparam int FBW  = 12;
  localparam int BON  = 16;
  localparam int RP2  = 64;
  localparam int BON2 = 4;
  localparam int ROWS = 1 << RAW;

  logic           clk_48mhz = 1'b0;
  logic           reset = 1'b1;
  logic [CH*DW-1:0] data_in = '0;
  logic [CH*DW-1:0] data_in2 = '0;
  logic [7:0]     brightness = 8'd0;

  logic [FBW-1:0] fb_addr, fb_addr2;
  logic [CH-1:0]  panel_data, panel_data2;
  logic           panel_clk, panel_latch, panel_oe_n, frame_done;
  logic           panel_clk2, panel_latch2, panel_oe_n2, frame_done2;
  logic [RAW-1:0] panel_addr, panel_addr2;
  logic [3:0]     dbg_state, dbg_state2;

  logic [CH*DW-1:0] fb_mem [0:(1<<FBW)-1];

  logic [FBW+CH-1:0] pix_q[$];
  logic [32:0]       lat_q[$];
  logic [63:0]       lit_q[$];
  logic [31:0]       fd_q[$];

  int n_vec = 0;
  int n_err = 0;
  int seg_end = 0;

  always #10 clk_48mhz = ~clk_48mhz;

  hub_bcm_driver #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .BITS(BITS), .ROW_ADDR_WIDTH(RAW),
    .ROW_PIXELS(RP), .FB_ADDR_WIDTH(FBW), .BASE_ON(BON)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .data_in(data_in), .brightness(brightness),
    .fb_addr(fb_addr), .panel_data(panel_data), .panel_clk(panel_clk),
    .panel_latch(panel_latch), .panel_oe_n(panel_oe_n), .panel_addr(panel_addr),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  hub_bcm_driver #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .BITS(BITS), .ROW_ADDR_WIDTH(RAW),
    .ROW_PIXELS(RP2), .FB_ADDR_WIDTH(FBW), .BASE_ON(BON2)
  ) dut_long (
    .clk_48mhz(clk_48mhz), .reset(reset), .data_in(data_in2), .brightness(brightness),
    .fb_addr(fb_addr2), .panel_data(panel_data2), .panel_clk(panel_clk2),
    .panel_latch(panel_latch2), .panel_oe_n(panel_oe_n2), .panel_addr(panel_addr2),
    .frame_done(frame_done2), .dbg_state(dbg_state2)
  );

  // Synchronous framebuffer, one cycle of read latency.
  always @(posedge clk_48mhz) begin
    data_in  <= fb_mem[fb_addr];
    data_in2 <= fb_mem[fb_addr2];
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  function automatic logic [FBW+CH-1:0] pix_exp(input int row, input int plane, input int x);
    int addr;
    logic [CH*DW-1:0] word;
    logic [CH-1:0] bits;
    logic [FBW-1:0] a;
    addr = row * RP + x;
    word = fb_mem[addr];
    for (int c = 0; c < CH; c++) bits[c] = word[c*DW + (DW - BITS) + plane];
    a = addr[FBW-1:0];
    return {a, bits};
  endfunction

  // Scoreboard monitor for the short-row instance.
  initial begin
    int cyc, run_start, run_len;
    bit prev_clk, prev_oe, in_run;
    logic [FBW-1:0] prev_fb;
    logic [FBW+CH-1:0] pe;
    logic [32:0] le;
    logic [63:0] re;
    cyc = 0; prev_clk = 0; prev_oe = 1; in_run = 0; prev_fb = '0;
    run_start = 0; run_len = 0;
    forever begin
      @(negedge clk_48mhz);
      if (reset) begin
        cyc = 0; prev_clk = 0; prev_oe = 1; in_run = 0;
      end else begin
        if (cyc <= seg_end) begin
          if (panel_clk && !prev_clk) begin
            if (pix_q.size() == 0) unexpected("pixel");
            else begin
              pe = pix_q.pop_front();
              check("pix_addr", prev_fb, pe[FBW+CH-1:CH]);
              check("pix_data", panel_data, pe[CH-1:0]);
            end
          end
          if (panel_latch) begin
            if (lat_q.size() == 0) unexpected("latch");
            else begin
              le = lat_q.pop_front();
              check("latch_cycle", cyc, le[32:1]);
              check("latch_row", panel_addr, le[0]);
            end
          end
          if (frame_done) begin
            if (fd_q.size() == 0) unexpected("frame_done");
            else check("frame_done_cycle", cyc, fd_q.pop_front());
          end
          if (!panel_oe_n && prev_oe) begin
            in_run = 1; run_start = cyc; run_len = 0;
          end
          if (!panel_oe_n) run_len++;
          if (panel_oe_n && !prev_oe && in_run) begin
            in_run = 0;
            if (lit_q.size() == 0) unexpected("lit_run");
            else begin
              re = lit_q.pop_front();
              check("lit_start", run_start, re[63:32]);
              check("lit_len", run_len, re[31:0]);
            end
          end
        end
        prev_clk = panel_clk; prev_fb = fb_addr; prev_oe = panel_oe_n;
        cyc++;
      end
    end
  end

  // Long-row instance: display ends long before the shift, so latches are shift-bound.
  initial begin
    int cyc2, last2, lit2, k2;
    cyc2 = 0; last2 = 0; lit2 = 0; k2 = 0;
    forever begin
      @(negedge clk_48mhz);
      if (reset) begin
        cyc2 = 0; last2 = 0; lit2 = 0; k2 = 0;
      end else begin
        if (!panel_oe_n2) lit2++;
        if (panel_latch2) begin
          if (k2 == 0) check("long_first_latch", cyc2, 2*RP2 + 2);
          else begin
            check("long_period", cyc2 - last2, 2*RP2 + 3);
            check("long_lit", lit2, ((BON2 << ((k2 - 1) % BITS)) * int'(brightness)) / 256);
          end
          last2 = cyc2; lit2 = 0; k2++;
        end
        cyc2++;
      end
    end
  end

  task automatic run_segment(input int n_lat, input int abort_rises, input logic [7:0] br,
                             input bit directed);
    int t_start, wait_t, b, l, prev_l, prev_win, prev_thr, row, plane, win;
    logic [31:0] lc;
    logic [RAW-1:0] rr;
    reset = 1'b1;
    pix_q.delete(); lat_q.delete(); lit_q.delete(); fd_q.delete();
    brightness = br;
    for (int a = 0; a < 256; a++) fb_mem[a] = directed ? 16'h4080 : 16'($urandom);
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check("rst_oe_n", panel_oe_n, 1);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_panel_clk", panel_clk, 0);
    check("rst_latch", panel_latch, 0);
    check("rst_panel_addr", panel_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_panel_data", panel_data, 0);

    if (abort_rises > 0) begin
      for (int x = 0; x < abort_rises; x++) pix_q.push_back(pix_exp(0, 0, x));
      seg_end = 2 * abort_rises;
    end else begin
      t_start = 0; prev_l = 0; prev_win = 0; prev_thr = 0;
      for (int k = 0; k < n_lat; k++) begin
        row = (k / BITS) % ROWS;
        plane = k % BITS;
        for (int x = 0; x < RP; x++) pix_q.push_back(pix_exp(row, plane, x));
        wait_t = t_start + 1 + 2*RP;
        b = (k == 0 || wait_t > prev_l + prev_win) ? wait_t : prev_l + prev_win;
        l = b + 1;
        lc = l; rr = row[RAW-1:0];
        lat_q.push_back({lc, rr});
        if (plane == BITS - 1 && row == ROWS - 1) fd_q.push_back(32'(l + 1));
        if (k > 0 && prev_thr > 0) lit_q.push_back({32'(prev_l + 1), 32'(prev_thr)});
        win = BON << plane;
        prev_thr = (win * int'(br)) / 256;
        prev_l = l; prev_win = win; t_start = l + 1;
      end
      seg_end = prev_l + 1;
    end

    @(posedge clk_48mhz);
    #1 reset = 1'b0;
    repeat (seg_end + 1) @(negedge clk_48mhz);
    #1;
    check("pending_pix", pix_q.size(), 0);
    check("pending_latch", lat_q.size(), 0);
    check("pending_lit", lit_q.size(), 0);
    check("pending_frame_done", fd_q.size(), 0);
  endtask

  initial begin
    run_segment(6, 0, 8'd255, 1'b1);
    run_segment(0, 2, 8'($urandom_range(1, 255)), 1'b0);
    run_segment(6, 0, 8'd128, 1'b0);
    run_segment(6, 0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_segment($urandom_range(3, 8), 0, 8'($urandom_range(0, 255)), 1'b0);
    end
    run_segment(20, 0, 8'd255, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
